tmr_seu_monitor: RTL and testbench

TMR_SEU_MONITOR -- requirements
Module: tmr_seu_monitor

---
 rtl/tmr_seu_monitor.sv | 125 ++++++++++++
 tb/tb_tmr_seu_monitor.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/tmr_seu_monitor.sv
// Majority voter for triplicated registers with per-lane disagreement tracking,
// sticky persistent-fault flags, a saturating error counter and a clear handshake.
module tmr_seu_monitor #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned PERSIST   = 4
) (
    input  logic                 clkA,
    input  logic                 rstA,
    input  logic [WIDTH-1:0]     inA,
    input  logic [WIDTH-1:0]     inB,
    input  logic [WIDTH-1:0]     inC,
    output logic [WIDTH-1:0]     voted,
    output logic                 err_pulse,
    output logic                 multi_err,
    output logic [1:0]           lane_id,
    output logic [2:0]           lane_fault,
    output logic [CNT_WIDTH-1:0] err_cnt,
    input  logic                 clr_req,
    output logic                 clr_ack
);

    localparam int unsigned          RUN_W     = 4;
    localparam logic [RUN_W-1:0]     PERSIST_V = RUN_W'(PERSIST);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    typedef enum logic {IDLE, ACK} clr_state_t;

    clr_state_t state, state_nxt;
    logic       clr_fire_c;

    logic [WIDTH-1:0]            maj_c;
    logic [2:0]                  dis_c;
    logic                        err_c;
    logic                        multi_c;
    logic                        single_c;
    logic [1:0]                  id_c;
    logic [2:0][RUN_W-1:0]       run_q;
    logic [2:0][RUN_W-1:0]       run_nxt_c;
    logic [2:0]                  fault_set_c;

    // Vote and per-lane disagreement against the combinational majority
    assign maj_c    = (inA & inB) | (inA & inC) | (inB & inC);
    assign dis_c    = {|(inC ^ maj_c), |(inB ^ maj_c), |(inA ^ maj_c)};
    assign err_c    = |dis_c;
    assign multi_c  = (dis_c[0] & dis_c[1]) | (dis_c[0] & dis_c[2]) | (dis_c[1] & dis_c[2]);
    assign single_c = err_c & ~multi_c;

    always_comb begin
        id_c = 2'd0;
        if (dis_c[0])      id_c = 2'd1;
        else if (dis_c[1]) id_c = 2'd2;
        else if (dis_c[2]) id_c = 2'd3;
    end

    // Run counters saturate at PERSIST; reaching it flags the lane
    always_comb begin
        run_nxt_c   = '0;
        fault_set_c = '0;
        for (int i = 0; i < 3; i++) begin
            if (!dis_c[i])
                run_nxt_c[i] = '0;
            else if (run_q[i] == PERSIST_V)
                run_nxt_c[i] = run_q[i];
            else
                run_nxt_c[i] = run_q[i] + RUN_W'(1);
            fault_set_c[i] = dis_c[i] && (run_nxt_c[i] == PERSIST_V);
        end
    end

    always_ff @(posedge clkA or posedge rstA) begin
        if (rstA) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        clr_fire_c = 1'b0;
        case (state)
            IDLE: if (clr_req) begin
                state_nxt  = ACK;
                clr_fire_c = 1'b1;
            end
            ACK:  if (!clr_req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clkA or posedge rstA) begin
        if (rstA) begin
            voted     <= '0;
            err_pulse <= 1'b0;
            multi_err <= 1'b0;
            clr_ack   <= 1'b0;
        end else begin
            voted     <= maj_c;
            err_pulse <= err_c;
            multi_err <= multi_c;
            clr_ack   <= (state_nxt == ACK);
        end
    end

    // Statistics; a clear takes priority over the sample it coincides with
    always_ff @(posedge clkA or posedge rstA) begin
        if (rstA) begin
            err_cnt    <= '0;
            lane_id    <= 2'd0;
            lane_fault <= 3'b000;
            run_q      <= '0;
        end else if (clr_fire_c) begin
            err_cnt    <= '0;
            lane_id    <= 2'd0;
            lane_fault <= 3'b000;
            run_q      <= '0;
        end else begin
            run_q      <= run_nxt_c;
            lane_fault <= lane_fault | fault_set_c;
            if (err_c && (err_cnt != CNT_MAX))
                err_cnt <= err_cnt + CNT_WIDTH'(1);
            if (single_c)
                lane_id <= id_c;
        end
    end

endmodule

// File: tb/tb_tmr_seu_monitor.sv
// Directed bench for tmr_seu_monitor (WIDTH=8, CNT_WIDTH=4, PERSIST=4).
module tb_tmr_seu_monitor;

    logic       clkA = 1'b0;
    logic       rstA;
    logic [7:0] inA, inB, inC;
    logic [7:0] voted;
    logic       err_pulse, multi_err;
    logic [1:0] lane_id;
    logic [2:0] lane_fault;
    logic [3:0] err_cnt;
    logic       clr_req, clr_ack;

    int checks = 0;
    int errors = 0;

    tmr_seu_monitor #(.WIDTH(8), .CNT_WIDTH(4), .PERSIST(4)) dut (
        .clkA(clkA), .rstA(rstA),
        .inA(inA), .inB(inB), .inC(inC),
        .voted(voted), .err_pulse(err_pulse), .multi_err(multi_err),
        .lane_id(lane_id), .lane_fault(lane_fault), .err_cnt(err_cnt),
        .clr_req(clr_req), .clr_ack(clr_ack)
    );

    always #5 clkA = ~clkA;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clkA);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        inA = a; inB = b; inC = c;
    endtask

    initial begin
        rstA = 1'b1; clr_req = 1'b0;
        drive(8'h00, 8'h00, 8'h00);
        repeat (2) step();
        chk("rst_voted", 32'(voted), 32'h00);
        chk("rst_err", 32'(err_pulse), 32'd0);
        chk("rst_multi", 32'(multi_err), 32'd0);
        chk("rst_id", 32'(lane_id), 32'd0);
        chk("rst_fault", 32'(lane_fault), 32'd0);
        chk("rst_cnt", 32'(err_cnt), 32'd0);
        chk("rst_ack", 32'(clr_ack), 32'd0);
        rstA = 1'b0;

        // All lanes agree
        drive(8'hA5, 8'hA5, 8'hA5);
        step();
        chk("agree_voted", 32'(voted), 32'hA5);
        chk("agree_err", 32'(err_pulse), 32'd0);
        chk("agree_cnt", 32'(err_cnt), 32'd0);

        // Single-bit upset on lane A
        drive(8'hA4, 8'hA5, 8'hA5);
        step();
        chk("a_voted", 32'(voted), 32'hA5);
        chk("a_err", 32'(err_pulse), 32'd1);
        chk("a_multi", 32'(multi_err), 32'd0);
        chk("a_id", 32'(lane_id), 32'd1);
        chk("a_cnt", 32'(err_cnt), 32'd1);
        chk("a_fault", 32'(lane_fault), 32'd0);

        drive(8'hA5, 8'hA5, 8'hA5);
        step();
        chk("a_rec_err", 32'(err_pulse), 32'd0);
        chk("a_rec_id", 32'(lane_id), 32'd1);
        chk("a_rec_cnt", 32'(err_cnt), 32'd1);

        // B bit3 and C bit0 upset in the same sample
        drive(8'hA5, 8'hAD, 8'hA4);
        step();
        chk("bc_voted", 32'(voted), 32'hA5);
        chk("bc_err", 32'(err_pulse), 32'd1);
        chk("bc_multi", 32'(multi_err), 32'd1);
        chk("bc_id", 32'(lane_id), 32'd1);
        chk("bc_cnt", 32'(err_cnt), 32'd2);

        drive(8'hA5, 8'hA5, 8'hA5);
        step();
        chk("bc_rec_multi", 32'(multi_err), 32'd0);

        // Lane C wrong for PERSIST samples
        drive(8'hA5, 8'hA5, 8'h5A);
        repeat (3) step();
        chk("c3_fault", 32'(lane_fault), 32'd0);
        chk("c3_cnt", 32'(err_cnt), 32'd5);
        step();
        chk("c4_fault", 32'(lane_fault), 32'b100);
        chk("c4_id", 32'(lane_id), 32'd3);
        chk("c4_cnt", 32'(err_cnt), 32'd6);
        drive(8'hA5, 8'hA5, 8'hA5);
        step();
        chk("c_rec_fault", 32'(lane_fault), 32'b100);
        chk("c_rec_err", 32'(err_pulse), 32'd0);

        // 20 error samples on lane A: counter saturates at 4'hF
        drive(8'h00, 8'hA5, 8'hA5);
        repeat (20) step();
        chk("sat_cnt", 32'(err_cnt), 32'hF);
        chk("sat_fault", 32'(lane_fault), 32'b101);
        chk("sat_voted", 32'(voted), 32'hA5);
        step();
        chk("sat_hold", 32'(err_cnt), 32'hF);

        // Clear coincident with a lane A error
        clr_req = 1'b1;
        drive(8'hA4, 8'hA5, 8'hA5);
        step();
        chk("clr_cnt", 32'(err_cnt), 32'd0);
        chk("clr_fault", 32'(lane_fault), 32'd0);
        chk("clr_id", 32'(lane_id), 32'd0);
        chk("clr_ack", 32'(clr_ack), 32'd1);
        chk("clr_err", 32'(err_pulse), 32'd1);
        step();
        chk("ack_hold", 32'(clr_ack), 32'd1);
        chk("ack_cnt", 32'(err_cnt), 32'd1);
        chk("ack_id", 32'(lane_id), 32'd1);
        clr_req = 1'b0;
        drive(8'hA5, 8'hA5, 8'hA5);
        step();
        chk("ack_drop", 32'(clr_ack), 32'd0);
        chk("ack_drop_cnt", 32'(err_cnt), 32'd1);

        // Fresh clear right after return to IDLE; clear sample must not advance run counter
        clr_req = 1'b1;
        drive(8'hA4, 8'hA5, 8'hA5);
        step();
        chk("clr2_ack", 32'(clr_ack), 32'd1);
        chk("clr2_cnt", 32'(err_cnt), 32'd0);
        clr_req = 1'b0;
        repeat (3) step();
        chk("clr2_run3_fault", 32'(lane_fault), 32'd0);
        chk("clr2_run3_cnt", 32'(err_cnt), 32'd3);
        step();
        chk("clr2_run4_fault", 32'(lane_fault), 32'b001);

        // Reset during a handshake aborts immediately
        clr_req = 1'b1;
        drive(8'hA5, 8'hA5, 8'hA5);
        step();
        chk("pre_rst_ack", 32'(clr_ack), 32'd1);
        rstA = 1'b1;
        #1;
        chk("mid_rst_ack", 32'(clr_ack), 32'd0);
        chk("mid_rst_cnt", 32'(err_cnt), 32'd0);
        chk("mid_rst_voted", 32'(voted), 32'h00);
        step();
        rstA = 1'b0; clr_req = 1'b0;
        drive(8'hA5, 8'hA5, 8'h25);
        step();
        chk("post_rst_err", 32'(err_pulse), 32'd1);
        chk("post_rst_id", 32'(lane_id), 32'd3);
        chk("post_rst_cnt", 32'(err_cnt), 32'd1);
        chk("post_rst_ack", 32'(clr_ack), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
